// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value and commits it to a 2**ADDR_W x DATA_W register file.
// Optional macro WB_BYPASS_EN turns the read ports into write-first bypassed reads.
module wb_regfile #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int LINK_OFFSET = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB_MemtoReg_wb,
  input  logic              WB_RegWrite_wb,
  input  logic [ADDR_W-1:0] RegWriteAddr_wb,
  input  logic [DATA_W-1:0] PC_wb,
  input  logic [DATA_W-1:0] ALUResult_wb,
  input  logic [DATA_W-1:0] MemOut_wb,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData_wb,
  output logic              WriteEn_wb
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] LINK_OFF = DATA_W'(LINK_OFFSET);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Encoding 2'b11 is reserved and falls back to the ALU result.
  always_comb begin
    WriteData_wb = ALUResult_wb;
    case (WB_MemtoReg_wb)
      2'b01:   WriteData_wb = MemOut_wb;
      2'b10:   WriteData_wb = PC_wb + LINK_OFF;
      default: WriteData_wb = ALUResult_wb;
    endcase
  end

  assign WriteEn_wb = WB_RegWrite_wb & (RegWriteAddr_wb != '0);

  always_comb begin
    regs_d = regs_q;
    if (WriteEn_wb) regs_d[RegWriteAddr_wb] = WriteData_wb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Reset and address 0 override everything, including the bypass path.
  always_comb begin
    ReadData1 = regs_q[ReadAddr1];
`ifdef WB_BYPASS_EN
    if (WriteEn_wb && (ReadAddr1 == RegWriteAddr_wb)) ReadData1 = WriteData_wb;
`endif
    if (!rst || (ReadAddr1 == '0)) ReadData1 = '0;
  end

  always_comb begin
    ReadData2 = regs_q[ReadAddr2];
`ifdef WB_BYPASS_EN
    if (WriteEn_wb && (ReadAddr2 == RegWriteAddr_wb)) ReadData2 = WriteData_wb;
`endif
    if (!rst || (ReadAddr2 == '0)) ReadData2 = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: array model of the register file checked every negedge,
// plus hand-computed literal expectations for each scenario.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WB_MemtoReg_wb;
  logic        WB_RegWrite_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic [31:0] PC_wb, ALUResult_wb, MemOut_wb;
  logic [4:0]  ReadAddr1, ReadAddr2;
  logic [31:0] ReadData1, ReadData2, WriteData_wb;
  logic        WriteEn_wb;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .WB_MemtoReg_wb(WB_MemtoReg_wb), .WB_RegWrite_wb(WB_RegWrite_wb),
    .RegWriteAddr_wb(RegWriteAddr_wb), .PC_wb(PC_wb),
    .ALUResult_wb(ALUResult_wb), .MemOut_wb(MemOut_wb),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteData_wb(WriteData_wb), .WriteEn_wb(WriteEn_wb)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] model_q [32];

  function automatic logic [31:0] model_wd();
    if (WB_MemtoReg_wb == 2'd1) return MemOut_wb;
    if (WB_MemtoReg_wb == 2'd2) return PC_wb + 32'd4;
    return ALUResult_wb;
  endfunction

  function automatic logic model_we();
    return WB_RegWrite_wb && (RegWriteAddr_wb != 5'd0);
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'd0;
    if (BYPASS && model_we() && a == RegWriteAddr_wb) return model_wd();
    return model_q[a];
  endfunction

  always @(posedge clk)
    if (rst === 1'b1 && model_we()) model_q[RegWriteAddr_wb] = model_wd();

  // scoreboard compare every negedge
  always @(negedge clk) begin
    if (!rst) for (int i = 0; i < 32; i++) model_q[i] = 32'd0;
    check("WriteData_wb", WriteData_wb, model_wd());
    check("WriteEn_wb", {31'd0, WriteEn_wb}, {31'd0, model_we()});
    check("ReadData1", ReadData1, model_rd(ReadAddr1));
    check("ReadData2", ReadData2, model_rd(ReadAddr2));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic we, input logic [1:0] sel, input logic [4:0] a,
                          input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    WB_RegWrite_wb  = we;
    WB_MemtoReg_wb  = sel;
    RegWriteAddr_wb = a;
    ALUResult_wb    = alu;
    MemOut_wb       = mem;
    PC_wb           = pc;
  endtask

  task automatic idle();
    drive_wr(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_q[i] = 32'd0;
    rst = 1'b0;
    ReadAddr1 = 5'd0;
    ReadAddr2 = 5'd0;
    idle();
    tick(); tick();
    rst = 1'b1;

    // Reset: preload reg[5], then assert reset and try to write reg[6] under it
    drive_wr(1'b1, 2'd0, 5'd5, 32'h1234, 32'd0, 32'd0);
    tick();
    idle();
    ReadAddr1 = 5'd5;
    @(negedge clk); check("preload_r5", ReadData1, 32'h1234);
    tick();
    rst = 1'b0;
    drive_wr(1'b1, 2'd0, 5'd6, 32'hCAFE, 32'd0, 32'd0);
    #1 check("reset_r5", ReadData1, 32'd0);
    tick(); tick();
    idle();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ReadAddr2 = 5'(i);
      #1 check("post_reset_all", ReadData2, 32'd0);
    end

    // ALU writeback
    drive_wr(1'b1, 2'd0, 5'd8, 32'hDEADBEEF, 32'h1, 32'h2);
    ReadAddr2 = 5'd8;
    @(negedge clk);
    check("alu_wd", WriteData_wb, 32'hDEADBEEF);
    check("alu_we", {31'd0, WriteEn_wb}, 32'd1);
    tick(); idle();
    @(negedge clk); check("alu_r8", ReadData2, 32'hDEADBEEF);

    // Load select
    tick();
    drive_wr(1'b1, 2'd1, 5'd9, 32'h1111, 32'h0000_00A5, 32'h0);
    @(negedge clk); check("load_wd", WriteData_wb, 32'hA5);
    tick(); idle(); ReadAddr1 = 5'd9;
    @(negedge clk); check("load_r9", ReadData1, 32'hA5);

    // Link select and wrap
    tick();
    drive_wr(1'b1, 2'd2, 5'd31, 32'h2222, 32'h3333, 32'h0040_0010);
    @(negedge clk); check("link_wd", WriteData_wb, 32'h0040_0014);
    tick();
    drive_wr(1'b1, 2'd0, 5'd30, 32'h77, 32'd0, 32'd0);
    ReadAddr1 = 5'd31;
    @(negedge clk); check("link_r31", ReadData1, 32'h0040_0014);
    tick();
    drive_wr(1'b1, 2'd2, 5'd30, 32'h4444, 32'h5555, 32'hFFFF_FFFC);
    ReadAddr2 = 5'd30;
    @(negedge clk); check("wrap_wd", WriteData_wb, 32'd0);
    tick(); idle();
    @(negedge clk); check("wrap_r30", ReadData2, 32'd0);

    // Reserved select 2'b11 falls back to ALU
    tick();
    drive_wr(1'b1, 2'd3, 5'd12, 32'h0BAD_F00D, 32'h6666, 32'h100);
    @(negedge clk); check("rsvd_wd", WriteData_wb, 32'h0BAD_F00D);

    // $0 protection
    tick();
    drive_wr(1'b1, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    ReadAddr1 = 5'd0;
    @(negedge clk);
    check("r0_we", {31'd0, WriteEn_wb}, 32'd0);
    check("r0_same", ReadData1, 32'd0);
    tick(); idle();
    @(negedge clk); check("r0_next", ReadData1, 32'd0);

    // Same-cycle hazard
    tick();
    drive_wr(1'b1, 2'd0, 5'd3, 32'd1, 32'd0, 32'd0);
    tick();
    drive_wr(1'b1, 2'd0, 5'd3, 32'd7, 32'd0, 32'd0);
    ReadAddr1 = 5'd3; ReadAddr2 = 5'd3;
    @(negedge clk);
    check("hazard_same", ReadData1, BYPASS ? 32'd7 : 32'd1);
    tick(); idle();
    @(negedge clk);
    check("hazard_next1", ReadData1, 32'd7);
    check("hazard_next2", ReadData2, 32'd7);

    // Write disabled
    tick();
    drive_wr(1'b0, 2'd0, 5'd4, 32'h55, 32'h66, 32'h77);
    ReadAddr1 = 5'd4;
    @(negedge clk); check("nowr_we", {31'd0, WriteEn_wb}, 32'd0);
    tick();
    @(negedge clk); check("nowr_r4", ReadData1, 32'd0);

    // Back-to-back writes with trailing reads, checked by the model
    for (int i = 10; i < 22; i++) begin
      tick();
      drive_wr(1'b1, 2'(i % 3), 5'(i), 32'h0101_0101 * i, 32'hA000_0000 + i, 32'h1000 * i);
      ReadAddr1 = 5'(i - 1);
      ReadAddr2 = 5'(i);
    end
    tick(); idle();

    // Reset asserted while a write is pending aborts it and clears everything
    drive_wr(1'b1, 2'd0, 5'd15, 32'h9999, 32'd0, 32'd0);
    rst = 1'b0;
    tick();
    idle();
    rst = 1'b1;
    ReadAddr1 = 5'd15; ReadAddr2 = 5'd31;
    #1;
    check("midreset_r15", ReadData1, 32'd0);
    check("midreset_r31", ReadData2, 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-end consumer of the MEM/WB pipeline register.
- Takes the registered writeback controls and data, selects the writeback value, and commits it to a 32x32 general-purpose register file on the rising clock edge.
- Provides two asynchronous read ports for the ID stage and a writeback-data output for the forwarding unit.
- Register $0 is hardwired to zero.

Parameters:
DATA_W, 32, datapath and register width
ADDR_W, 5, register address width; the file holds 2**ADDR_W entries
LINK_OFFSET, 4, byte offset added to PC_wb for link writes (jal/jalr)

Ports:
clk  input  1  system clock, rising edge active
rst  input  1  asynchronous reset, active-low; clears the entire register file
WB_MemtoReg_wb  input  2  writeback source select
WB_RegWrite_wb  input  1  register write enable
RegWriteAddr_wb  input  ADDR_W  destination register
PC_wb  input  DATA_W  PC of the instruction in WB
ALUResult_wb  input  DATA_W  ALU result
MemOut_wb  input  DATA_W  load data
ReadAddr1  input  ADDR_W  read port 1 address
ReadAddr2  input  ADDR_W  read port 2 address
ReadData1  output  DATA_W  read port 1 data
ReadData2  output  DATA_W  read port 2 data
WriteData_wb  output  DATA_W  selected writeback value, for forwarding
WriteEn_wb  output  1  effective write strobe, for forwarding

Behaviour:
- Reset:
  - While rst=0, all 2**ADDR_W registers are asynchronously cleared to 0.
  - ReadData1/2 read 0 during reset.
  - Release of rst is synchronised by the integrator; no write occurs on any edge where rst=0.
- Writeback select (combinational), output on WriteData_wb:
  - 2'b00 -> ALUResult_wb
  - 2'b01 -> MemOut_wb
  - 2'b10 -> PC_wb + LINK_OFFSET, truncated to DATA_W (wraps: 32'hFFFFFFFC + 4 = 0)
  - 2'b11 -> ALUResult_wb (reserved encoding)
- Write strobe:
  - WriteEn_wb = WB_RegWrite_wb & (RegWriteAddr_wb != 0).
- Commit:
  - On the rising edge of clk with rst=1 and WriteEn_wb=1, reg[RegWriteAddr_wb] <= WriteData_wb.
  - Write latency is 1 cycle: the value is architecturally visible from the next cycle.
- Register $0:
  - Writes to address 0 are dropped.
  - Reads of address 0 always return 0, regardless of bypass.
- Read ports:
  - Purely combinational: ReadDataN = reg[ReadAddrN], modified only by the optional bypass.
  - Both ports may address the same register simultaneously; both return identical data.
- Same-cycle write and read to the same address: result defined by WB_BYPASS_EN (see Optional Feature).
- X-safety:
  - WB_RegWrite_wb=0 never modifies state, regardless of the other inputs.
  - Addresses are always in range (the file is a full 2**ADDR_W entries).
- Reset mid-operation:
  - Assertion during a write edge aborts the write.
  - All entries read 0 afterwards.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined: write-first internal bypass.
  - If WriteEn_wb=1 and ReadAddrN == RegWriteAddr_wb (nonzero), ReadDataN = WriteData_wb in the same cycle.
  - Removes the WB->ID hazard, so the hazard unit needs no stall for this case.
- Undefined: read-before-write.
  - ReadDataN returns the old register contents until the clock edge.
  - The hazard/forwarding logic must cover the WB->ID distance.

Test Plan:
- Reset: hold rst=0 for 2 cycles after preloading reg[5]=32'h1234 -> ReadData1 with ReadAddr1=5 reads 0; all 32 entries read 0 after release.
- ALU writeback: MemtoReg=00, RegWrite=1, addr=8, ALUResult=32'hDEADBEEF, one edge -> ReadData2 with ReadAddr2=8 returns 32'hDEADBEEF next cycle; WriteData_wb=32'hDEADBEEF during the write cycle.
- Load and link select:
  - MemtoReg=01, MemOut=32'h0000_00A5, addr=9 -> reg[9]=32'hA5.
  - MemtoReg=10, PC_wb=32'h0040_0010, addr=31 -> reg[31]=32'h0040_0014.
  - PC_wb=32'hFFFFFFFC -> 0.
- $0 protection: RegWrite=1, addr=0, ALUResult=32'hFFFFFFFF -> WriteEn_wb=0; ReadData1 with ReadAddr1=0 stays 0 on both builds.
- Same-cycle hazard: reg[3]=1; write addr=3, data=7, ReadAddr1=3 in the same cycle -> ReadData1=7 with WB_BYPASS_EN, 1 without; 7 on both builds next cycle.
- Write disabled: RegWrite=0, addr=4, ALUResult=32'h55 -> reg[4] unchanged (0); WriteEn_wb=0.
